// File: rtl/seg_pkg.sv
// Seven-segment pattern constants shared by the display encoder and the scan decoder.
// Patterns are active-low with bit0 = segment a through bit6 = segment g.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DWELL_UNSTABLE,
    DWELL_CAPTURE,
    DWELL_HELD
  } dwell_state_t;

  // Forward mapping used by the encoder side of the display path.
  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t pattern;
    case (nibble)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_E;
      default: pattern = SEG_F;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup: exact-match a seven-segment pattern back to its hex nibble.
// Unrecognised patterns (including blank) report valid=0 and nibble 0.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  seg_t       seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed active-low seven-segment bus and rebuilds the displayed hex value.
// Optional ERR_COUNT_EN adds a saturating count of frames that contained a bad pattern.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  seg_t                    seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    frame_err
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRECAP = CW'(STABLE_CYCLES - 2);

  logic [NUM_DIGITS-1:0]   prev_sel;
  seg_t                    prev_seg;
  logic [CW-1:0]           stable_cnt;
  dwell_state_t            state;

  logic                    sel_valid;
  logic                    stable_now;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_hit;

  logic                    dec_valid;
  logic [3:0]              dec_nibble;

  logic [4*NUM_DIGITS-1:0] nibbles, nibbles_next;
  logic [NUM_DIGITS-1:0]   dig_err, err_next;
  logic [NUM_DIGITS-1:0]   mask, mask_next;
  logic                    frame_done;

  assign sel_valid  = $onehot(~dig_sel);
  assign stable_now = sel_valid && (dig_sel == prev_sel) && (seg_in == prev_seg);

  // The counter is at STABLE_CYCLES-2 only once per dwell, so this fires on the dwell's N-th identical cycle.
  assign capture    = stable_now && (stable_cnt == CNT_PRECAP) && (state == DWELL_UNSTABLE);
  assign cap_hit    = capture ? ~dig_sel : '0;
  assign frame_done = &mask;

  seg_pattern_decode u_decode (
    .seg    (seg_in),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel   <= '0;
      prev_seg   <= '0;
      stable_cnt <= '0;
      state      <= DWELL_UNSTABLE;
    end else begin
      prev_sel <= dig_sel;
      prev_seg <= seg_in;
      if (!stable_now)
        stable_cnt <= '0;
      else if (stable_cnt != CNT_SAT)
        stable_cnt <= stable_cnt + CW'(1);
      case (state)
        DWELL_UNSTABLE: if (capture) state <= DWELL_CAPTURE;
        DWELL_CAPTURE:  state <= stable_now ? DWELL_HELD : DWELL_UNSTABLE;
        DWELL_HELD:     if (!stable_now) state <= DWELL_UNSTABLE;
        default:        state <= DWELL_UNSTABLE;
      endcase
    end
  end

  // A completing frame clears the mask first so a coincident capture lands in the new frame.
  always_comb begin
    mask_next    = frame_done ? '0 : mask;
    err_next     = frame_done ? '0 : dig_err;
    nibbles_next = nibbles;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_hit[i]) begin
        mask_next[i]          = 1'b1;
        err_next[i]           = ~dec_valid;
        nibbles_next[4*i +: 4] = dec_nibble;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibbles     <= '0;
      dig_err     <= '0;
      mask        <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      nibbles     <= nibbles_next;
      dig_err     <= err_next;
      mask        <= mask_next;
      frame_valid <= frame_done;
      if (frame_done) begin
        frame_data <= nibbles;
        frame_err  <= |dig_err;
      end
    end
  end

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (frame_done && (|dig_err) && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scans plus randomized dwells against a frame-level model.
// Exercises the err_count output as well when ERR_COUNT_EN is defined.
module tb_seg_scan_decoder;

  localparam int N = 4;
  localparam int S = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     seg_in;
  logic [N-1:0]   dig_sel;
  logic [4*N-1:0] frame_data;
  logic           frame_valid;
  logic           frame_err;
`ifdef ERR_COUNT_EN
  logic [7:0]     err_count;
`endif

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
`ifdef ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference glyph table, index = hex value, MSB = segment g.
  bit [6:0] ref_pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  bit [3:0]       m_nib [N];
  bit             m_err [N];
  bit             m_cap [N];
  logic [4*N-1:0] last_data;
  bit             last_err;
  int             m_err_count;

  logic [4*N-1:0] exp_data_q [$];
  bit             exp_err_q  [$];
  logic [4*N-1:0] obs_data_q [$];
  bit             obs_err_q  [$];

  bit [N-1:0]     prev_sel;
  bit [6:0]       prev_seg;

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      obs_data_q.push_back(frame_data);
      obs_err_q.push_back(frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cap[i] = 1'b0;
      m_err[i] = 1'b0;
      m_nib[i] = 4'h0;
    end
    last_data   = '0;
    last_err    = 1'b0;
    m_err_count = 0;
  endtask

  // A dwell of at least S identical cycles on a single active digit yields one capture.
  task automatic model_dwell(input bit [N-1:0] sel, input bit [6:0] seg, input int len);
    int             k;
    bit             all;
    bit             e;
    logic [4*N-1:0] d;
    bit [N-1:0]     act;
    act = ~sel;
    if ($countones(act) != 1 || len < S) return;
    k = 0;
    for (int i = 0; i < N; i++) if (act[i]) k = i;
    m_nib[k] = 4'h0;
    m_err[k] = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (ref_pat[j] == seg) begin
        m_nib[k] = 4'(j);
        m_err[k] = 1'b0;
      end
    end
    m_cap[k] = 1'b1;
    all = 1'b1;
    for (int i = 0; i < N; i++) all &= m_cap[i];
    if (all) begin
      d = '0;
      e = 1'b0;
      for (int i = 0; i < N; i++) begin
        d[4*i +: 4] = m_nib[i];
        e |= m_err[i];
        m_cap[i] = 1'b0;
        m_err[i] = 1'b0;
      end
      exp_data_q.push_back(d);
      exp_err_q.push_back(e);
      last_data = d;
      last_err  = e;
      if (e && m_err_count < 255) m_err_count++;
    end
  endtask

  task automatic applyStimulus(input bit [N-1:0] sel, input bit [6:0] seg, input int len);
    dig_sel  = sel;
    seg_in   = seg;
    prev_sel = sel;
    prev_seg = seg;
    repeat (len) @(negedge clk);
    model_dwell(sel, seg, len);
  endtask

  task automatic checkOutput(input string tag);
    int n;
    applyStimulus('1, 7'h7F, 4);
    check({tag, ".frames"}, obs_data_q.size(), exp_data_q.size());
    n = (obs_data_q.size() < exp_data_q.size()) ? obs_data_q.size() : exp_data_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".data"}, obs_data_q[i], exp_data_q[i]);
      check({tag, ".err"},  obs_err_q[i],  exp_err_q[i]);
    end
    obs_data_q.delete();
    obs_err_q.delete();
    exp_data_q.delete();
    exp_err_q.delete();
    check({tag, ".hold_data"}, frame_data,  last_data);
    check({tag, ".hold_err"},  frame_err,   last_err);
    check({tag, ".valid_low"}, frame_valid, 1'b0);
`ifdef ERR_COUNT_EN
    check({tag, ".err_count"}, err_count, m_err_count);
`endif
  endtask

  task automatic scan(input bit [6:0] p0, input bit [6:0] p1, input bit [6:0] p2,
                      input bit [6:0] p3, input int len0, input int len);
    applyStimulus(4'b1110, p0, len0);
    applyStimulus(4'b1101, p1, len);
    applyStimulus(4'b1011, p2, len);
    applyStimulus(4'b0111, p3, len);
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int         order [4];
    int         j;
    int         t;
    bit [N-1:0] sel;
    bit [6:0]   seg;

    rst_n   = 1'b0;
    dig_sel = '1;
    seg_in  = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.data",  frame_data,  '0);
    check("reset.valid", frame_valid, 1'b0);
    check("reset.err",   frame_err,   1'b0);
`ifdef ERR_COUNT_EN
    check("reset.err_count", err_count, 8'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clean scan");
    scan(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 10, 10);
    checkOutput("clean");
    check("clean.value", frame_data, 16'h4321);

    $display("[TB] blank digit");
    scan(7'b1111001, 7'b0100100, 7'b1111111, 7'b0011001, 10, 10);
    checkOutput("blank");
    check("blank.value", frame_data, 16'h4021);
    check("blank.flag",  frame_err,  1'b1);

    $display("[TB] short dwell");
    scan(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, S - 1, 10);
    checkOutput("short");
    scan(7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, S, S);
    checkOutput("after_short");

    $display("[TB] invalid selects");
    applyStimulus(4'b1100, 7'b1111001, 20);
    applyStimulus(4'b1111, 7'b0100100, 20);
    applyStimulus(4'b1101, 7'b0001000, 10);
    applyStimulus(4'b1011, 7'b0000011, 10);
    applyStimulus(4'b0111, 7'b1000110, 10);
    checkOutput("bad_sel");
    applyStimulus(4'b1110, 7'b0100001, 10);
    checkOutput("bad_sel_done");

    $display("[TB] reset mid-frame");
    applyStimulus(4'b1110, 7'b0000110, 10);
    applyStimulus(4'b1101, 7'b0001110, 10);
    checkOutput("pre_reset");
    pulse_reset(2);
    applyStimulus(4'b1011, 7'b0010010, 10);
    applyStimulus(4'b0111, 7'b0011001, 10);
    checkOutput("post_reset");
    scan(7'b0000110, 7'b0001110, 7'b0010010, 7'b0011001, 10, 10);
    checkOutput("post_reset_full");

    $display("[TB] randomized scans");
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < 4; i++) order[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        sel = ~(N'(1) << order[i]);
        seg = ($urandom_range(9, 0) < 8) ? ref_pat[$urandom_range(15, 0)] : 7'($urandom);
        if (sel == prev_sel && seg == prev_seg) seg[0] = ~seg[0];
        applyStimulus(sel, seg, $urandom_range(S + 3, S - 1));
      end
      if (f % 4 == 3) begin
        for (int i = 0; i < 3; i++) begin
          sel = N'($urandom);
          seg = 7'($urandom);
          if (sel == prev_sel && seg == prev_seg) seg[0] = ~seg[0];
          applyStimulus(sel, seg, $urandom_range(S + 4, 1));
        end
      end
      checkOutput("random");
    end

`ifdef ERR_COUNT_EN
    $display("[TB] error count saturation");
    for (int f = 0; f < 300; f++)
      scan(7'b1111001, 7'b0100100, 7'b1111111, 7'b0011001, S, S);
    checkOutput("saturate");
    check("saturate.count", err_count, 8'd255);
    scan(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, S, S);
    checkOutput("saturate_clean");
    check("saturate_clean.count", err_count, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
